// File: rtl/pipeline_trace_buffer.sv
// pipeline_trace_buffer
// On-chip trace capture for the CPU pipeline. Snoops NUM_STAGES valid/ready
// handshakes and writes one entry per cycle in which any stage fires into a
// circular RAM. Capture runs in a pre/post-trigger window. Entries are then
// drained oldest-first over an AXIS-style read stream.
// Entry layout: {stall_map (optional), timestamp, fire_map, payload}.
// Optional feature: define PIPELINE_TRACE_STALL_EN to add a per-entry stall_map
// (valid & ~ready) and to also store stall-only cycles. Stall-only cycles never
// trigger.
module pipeline_trace_buffer #(
    parameter int NUM_STAGES      = 5,
    parameter int PAYLOAD_WIDTH   = 32,
    parameter int DEPTH           = 256,
    parameter int TIMESTAMP_WIDTH = 16,
    parameter int POST_TRIGGER    = 64,
    localparam int SEL_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1,
`ifdef PIPELINE_TRACE_STALL_EN
    localparam int ENTRY_W = NUM_STAGES + TIMESTAMP_WIDTH + NUM_STAGES + PAYLOAD_WIDTH
`else
    localparam int ENTRY_W = TIMESTAMP_WIDTH + NUM_STAGES + PAYLOAD_WIDTH
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_STAGES-1:0]               stage_tvalid,
    input  logic [NUM_STAGES-1:0]               stage_tready,
    input  logic [NUM_STAGES*PAYLOAD_WIDTH-1:0] stage_payload,
    input  logic                                arm,
    input  logic [SEL_W-1:0]                    capture_stage,
    input  logic [NUM_STAGES-1:0]               trig_mask,
    input  logic [PAYLOAD_WIDTH-1:0]            trig_value,
    output logic                                rd_tvalid,
    input  logic                                rd_tready,
    output logic [ENTRY_W-1:0]                  rd_tdata,
    output logic                                rd_tlast,
    output logic [1:0]                          state,
    output logic [CW-1:0]                       entry_count
);

    // Reject configurations the circular addressing cannot support.
    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "pipeline_trace_buffer: DEPTH must be a power of 2 and >= 4");
    end
    if ((POST_TRIGGER < 1) || (POST_TRIGGER > DEPTH - 1)) begin : g_bad_post
        $fatal(1, "pipeline_trace_buffer: POST_TRIGGER must be in 1..DEPTH-1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [TIMESTAMP_WIDTH-1:0] r_cycle_cnt;
    logic [SEL_W-1:0]           r_cap_stage;
    logic [NUM_STAGES-1:0]      r_trig_mask;
    logic [PAYLOAD_WIDTH-1:0]   r_trig_value;
    logic [AW-1:0]              r_wr_ptr;
    logic [CW-1:0]              r_entry_count;
    logic [AW-1:0]              r_post_cnt;

    logic [ENTRY_W-1:0]         r_mem [DEPTH];
    logic [ENTRY_W-1:0]         r_ram_dout;

    // Drain side: r_head is the next entry to move into the output register,
    // r_left counts entries not yet moved, r_ram_ok means r_ram_dout == mem[r_head].
    logic [AW-1:0]              r_head;
    logic [CW-1:0]              r_left;
    logic                       r_ram_ok;
    logic                       r_out_valid;
    logic                       r_out_last;
    logic [ENTRY_W-1:0]         r_out_data;

    logic [NUM_STAGES-1:0]      w_fire;
    logic                       w_capturing;
    logic                       w_store;
    logic [PAYLOAD_WIDTH-1:0]   w_cap_payload;
    logic [PAYLOAD_WIDTH-1:0]   w_trig_payload;
    logic                       w_trig_hit;
    logic                       w_trigger;
    logic [ENTRY_W-1:0]         w_entry;
    logic [AW-1:0]              w_wr_ptr_inc;
    logic [CW-1:0]              w_count_inc;
    logic [AW-1:0]              w_drain_start;
    logic                       w_pop;
    logic                       w_load;
    logic [AW-1:0]              w_head_nxt;

    assign w_fire      = stage_tvalid & stage_tready;
    assign w_capturing = (r_state == ST_ARMED) || (r_state == ST_POST);

`ifdef PIPELINE_TRACE_STALL_EN
    logic [NUM_STAGES-1:0]      w_stall;
    assign w_stall = stage_tvalid & ~stage_tready;
    assign w_store = w_capturing && ((|w_fire) || (|w_stall));
    assign w_entry = {w_stall, r_cycle_cnt, w_fire, w_cap_payload};
`else
    assign w_store = w_capturing && (|w_fire);
    assign w_entry = {r_cycle_cnt, w_fire, w_cap_payload};
`endif

    // Select the payload of the latched capture stage.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_cap_payload = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_cap_stage == SEL_W'(i)) begin
                w_cap_payload = stage_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    // Payload of the lowest-index stage that both fires and is in the trigger mask.
    always_comb begin
        w_trig_payload = '0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (w_fire[i] && r_trig_mask[i]) begin
                w_trig_payload = stage_payload[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
            end
        end
    end

    assign w_trig_hit = |(w_fire & r_trig_mask);
    assign w_trigger  = (r_state == ST_ARMED) && w_store && w_trig_hit &&
                        (w_trig_payload == r_trig_value);

    assign w_wr_ptr_inc  = r_wr_ptr + AW'(1);
    assign w_count_inc   = (r_entry_count == CW'(DEPTH)) ? r_entry_count
                                                         : r_entry_count + CW'(1);
    // Oldest entry once the store that enters DRAIN has landed.
    assign w_drain_start = w_wr_ptr_inc - w_count_inc[AW-1:0];

    assign w_pop      = r_out_valid && rd_tready;
    assign w_load     = (r_state == ST_DRAIN) && r_ram_ok && (r_left != '0) &&
                        (!r_out_valid || rd_tready);
    assign w_head_nxt = w_load ? (r_head + AW'(1)) : r_head;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: arm, trigger, post-trigger countdown, drain completion.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:  if (arm) w_state_nxt = ST_ARMED;
            ST_ARMED: if (w_trigger) w_state_nxt = (POST_TRIGGER == 1) ? ST_DRAIN : ST_POST;
            ST_POST:  if (w_store && (r_post_cnt == AW'(1))) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_pop && r_out_last) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Cycle stamp, config latch, write pointer, occupancy and post-trigger count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_cap_stage   <= '0;
            r_trig_mask   <= '0;
            r_trig_value  <= '0;
            r_wr_ptr      <= '0;
            r_entry_count <= '0;
            r_post_cnt    <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + TIMESTAMP_WIDTH'(1);
            if ((r_state == ST_IDLE) && arm) begin
                r_cap_stage   <= capture_stage;
                r_trig_mask   <= trig_mask;
                r_trig_value  <= trig_value;
                r_wr_ptr      <= '0;
                r_entry_count <= '0;
            end else if (w_store) begin
                r_wr_ptr      <= w_wr_ptr_inc;
                r_entry_count <= w_count_inc;
            end else if (w_pop && r_out_last) begin
                r_entry_count <= '0;
            end
            if (w_trigger) begin
                r_post_cnt <= AW'(POST_TRIGGER - 1);
            end else if ((r_state == ST_POST) && w_store) begin
                r_post_cnt <= r_post_cnt - AW'(1);
            end
        end
    end

    // Trace RAM: write on store cycles, synchronous read of the next head entry.
    // NOTE: the RAM array is deliberately not reset so it maps onto block RAM; it is only read after being written.
    always_ff @(posedge clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= w_entry;
        end
        r_ram_dout <= r_mem[w_head_nxt];
    end

    // Drain: prime the RAM read on entry, then stream through a prefetching output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_head      <= '0;
            r_left      <= '0;
            r_ram_ok    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if ((w_state_nxt == ST_DRAIN) && (r_state != ST_DRAIN)) begin
                r_head   <= w_drain_start;
                r_left   <= w_count_inc;
                r_ram_ok <= 1'b0;
            end else if (r_state == ST_DRAIN) begin
                r_ram_ok <= 1'b1;
                if (w_load) begin
                    r_head <= r_head + AW'(1);
                    r_left <= r_left - CW'(1);
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_ram_dout;
                r_out_last  <= (r_left == CW'(1));
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign rd_tvalid   = r_out_valid;
    assign rd_tdata    = r_out_data;
    assign rd_tlast    = r_out_last;
    assign state       = r_state;
    assign entry_count = r_entry_count;

endmodule

// File: tb/tb_pipeline_trace_buffer.sv
// Self-checking bench for pipeline_trace_buffer (DEPTH=16, POST_TRIGGER=4).
// A queue-based reference model keeps the surviving trace window and the
// capture phase. Directed scenarios are followed by randomized capture rounds.
module tb_pipeline_trace_buffer;

    localparam int NS    = 5;
    localparam int PW    = 32;
    localparam int DEPTH = 16;
    localparam int TSW   = 16;
    localparam int POST  = 4;
`ifdef PIPELINE_TRACE_STALL_EN
    localparam int EW    = NS + TSW + NS + PW;
`else
    localparam int EW    = TSW + NS + PW;
`endif
    localparam int FIRE_LO = PW;
    localparam int TS_LO   = PW + NS;

    typedef logic [EW-1:0] entry_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS-1:0]     stage_tvalid;
    logic [NS-1:0]     stage_tready;
    logic [NS*PW-1:0]  stage_payload;
    logic              arm;
    logic [2:0]        capture_stage;
    logic [NS-1:0]     trig_mask;
    logic [PW-1:0]     trig_value;
    logic              rd_tvalid;
    logic              rd_tready;
    logic [EW-1:0]     rd_tdata;
    logic              rd_tlast;
    logic [1:0]        state;
    logic [4:0]        entry_count;

    always #5 clk = ~clk;

    pipeline_trace_buffer #(
        .NUM_STAGES(NS), .PAYLOAD_WIDTH(PW), .DEPTH(DEPTH),
        .TIMESTAMP_WIDTH(TSW), .POST_TRIGGER(POST)
    ) dut (
        .clk(clk), .rst(rst),
        .stage_tvalid(stage_tvalid), .stage_tready(stage_tready),
        .stage_payload(stage_payload), .arm(arm),
        .capture_stage(capture_stage), .trig_mask(trig_mask), .trig_value(trig_value),
        .rd_tvalid(rd_tvalid), .rd_tready(rd_tready), .rd_tdata(rd_tdata),
        .rd_tlast(rd_tlast), .state(state), .entry_count(entry_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 idle, 1 armed, 2 post-trigger, 3 drain
    entry_t         m_q[$];
    entry_t         got_q[$];
    int             m_phase = 0;
    int             m_post_left = 0;
    logic [TSW-1:0] m_cnt = '0;
    logic [2:0]     m_cap = '0;
    logic [NS-1:0]  m_mask = '0;
    logic [PW-1:0]  m_val = '0;

    function automatic logic [PW-1:0] pl(input int i);
        return stage_payload[i*PW +: PW];
    endfunction

    task automatic model_edge();
        logic [NS-1:0] fire;
        logic [NS-1:0] stall;
        bit            store;
        int            low;
        entry_t        e;
        if (rst) begin
            m_phase = 0; m_post_left = 0; m_cnt = '0;
            m_q.delete();
            return;
        end
        fire = stage_tvalid & stage_tready;
`ifdef PIPELINE_TRACE_STALL_EN
        stall = stage_tvalid & ~stage_tready;
        e = {stall, m_cnt, fire, pl(int'(m_cap))};
`else
        stall = '0;
        e = {m_cnt, fire, pl(int'(m_cap))};
`endif
        store = ((m_phase == 1) || (m_phase == 2)) && ((fire != 0) || (stall != 0));
        if ((m_phase == 0) && arm) begin
            m_cap = capture_stage; m_mask = trig_mask; m_val = trig_value;
            m_q.delete();
            m_phase = 1;
        end else if (store) begin
            m_q.push_back(e);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            if (m_phase == 1) begin
                low = -1;
                for (int i = 0; i < NS; i++) begin
                    if (fire[i] && m_mask[i]) begin
                        low = i;
                        break;
                    end
                end
                if ((low >= 0) && (pl(low) == m_val)) begin
                    m_post_left = POST - 1;
                    m_phase = (POST == 1) ? 3 : 2;
                end
            end else begin
                m_post_left--;
                if (m_post_left == 0) m_phase = 3;
            end
        end
        m_cnt++;
    endtask

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        if (m_phase != 3) begin
            check("state", state, m_phase);
            check("entry_count", entry_count, m_q.size());
        end
    endtask

    task automatic idle_stages();
        stage_tvalid = '0; stage_tready = '0; stage_payload = '0;
    endtask

    task automatic random_stages();
        stage_tvalid = ($urandom_range(0, 9) < 4) ? '0 : NS'($urandom);
        stage_tready = NS'($urandom);
        for (int i = 0; i < NS; i++) stage_payload[i*PW +: PW] = PW'($urandom_range(0, 15));
    endtask

    task automatic force_trigger();
        int lo;
        lo = 0;
        for (int i = NS - 1; i >= 0; i--) if (m_mask[i]) lo = i;
        stage_tvalid = NS'(1) << lo;
        stage_tready = NS'(1) << lo;
        stage_payload[lo*PW +: PW] = m_val;
    endtask

    task automatic arm_with(input logic [2:0] cap, input logic [NS-1:0] mask, input logic [PW-1:0] val);
        capture_stage = cap; trig_mask = mask; trig_value = val;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig_value = 32'hDEAD_BEEF;
        trig_mask = '1;
    endtask

    // mode: 0 always ready, 1 toggling, 2 random. stop_after < 0 drains fully.
    task automatic drain(input int mode, input int stop_after);
        int     n, idx, budget, wait_cyc;
        bit     held, seen;
        entry_t held_d;
        logic   held_l;
        n = m_q.size(); idx = 0; held = 0; seen = 0; wait_cyc = 0;
        held_d = '0; held_l = 1'b0;
        got_q.delete();
        check("drain_entry_count", entry_count, n);
        check("drain_state", state, 3);
        budget = 8 * DEPTH + 20;
        while ((idx < n) && (budget > 0) && ((stop_after < 0) || (idx < stop_after))) begin
            case (mode)
                0:       rd_tready = 1'b1;
                1:       rd_tready = ((budget % 2) != 0);
                default: rd_tready = 1'($urandom_range(0, 1));
            endcase
            if (!seen) begin
                if (rd_tvalid) begin
                    seen = 1;
                    check("first_valid_late", wait_cyc > 2, 0);
                end else begin
                    wait_cyc++;
                end
            end
            if (held) begin
                check("hold_valid", rd_tvalid, 1);
                check("hold_data", rd_tdata, held_d);
                check("hold_last", rd_tlast, held_l);
            end
            held = 0;
            if (rd_tvalid) begin
                if (rd_tready) begin
                    check("beat_data", rd_tdata, m_q[idx]);
                    check("beat_last", rd_tlast, idx == n - 1);
                    got_q.push_back(rd_tdata);
                    idx++;
                end else begin
                    held = 1; held_d = rd_tdata; held_l = rd_tlast;
                end
            end
            tick();
            budget--;
        end
        rd_tready = 1'b0;
        if (stop_after < 0) begin
            check("drain_beats", idx, n);
            check("idle_state", state, 0);
            check("idle_count", entry_count, 0);
            check("idle_valid", rd_tvalid, 0);
            m_phase = 0;
            m_q.delete();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; arm = 1'b0; rd_tready = 1'b0;
        capture_stage = '0; trig_mask = '0; trig_value = '0;
        idle_stages();

        // Reset held three cycles.
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_valid", rd_tvalid, 0);
        check("rst_count", entry_count, 0);
        check("rst_last", rd_tlast, 0);
        check("rst_data", rd_tdata, 0);
        rst = 1'b0;

        // Armed with no fires: nothing stored.
        arm_with(3'd0, 5'b00001, 32'h120);
        repeat (50) tick();
        check("no_fire_count", entry_count, 0);

        // Directed window: PCs 0x100, 0x104, ... trigger at 0x120; arm pulsed during POST.
        k = 0;
        while ((m_phase != 3) && (k < 40)) begin
            stage_tvalid = 5'b00001; stage_tready = 5'b00001;
            stage_payload[0 +: PW] = 32'h100 + 32'(4 * k);
            arm = (m_phase == 2);
            tick();
            k++;
        end
        arm = 1'b0;
        idle_stages();
        check("dir_count", entry_count, 12);
        drain(0, -1);
        check("dir_beats", got_q.size(), 12);
        for (int i = 0; i < got_q.size(); i++) begin
            check("dir_payload", got_q[i][PW-1:0], 32'h100 + 32'(4 * i));
            if (i > 0) check("dir_ts_step", got_q[i][TS_LO +: TSW] - got_q[i-1][TS_LO +: TSW], 1);
        end

        // Wrap: 40 non-matching fires, trigger, post entries; toggling ready.
        arm_with(3'd0, 5'b00001, 32'h120);
        k = 0;
        while ((m_phase != 3) && (k < 60)) begin
            stage_tvalid = 5'b00001; stage_tready = 5'b00001;
            stage_payload[0 +: PW] = (k < 40) ? 32'h200 + 32'(4 * k) :
                                     (k == 40) ? 32'h120 : 32'h300 + 32'(4 * k);
            tick();
            k++;
        end
        idle_stages();
        check("wrap_count", entry_count, 16);
        drain(1, -1);
        check("wrap_beats", got_q.size(), 16);
        if (got_q.size() == 16) begin
            check("wrap_oldest", got_q[0][PW-1:0], 32'h270);
            check("wrap_newest", got_q[15][PW-1:0], 32'h3AC);
        end

`ifdef PIPELINE_TRACE_STALL_EN
        // Stall-only cycles: stored with stall_map, never trigger.
        arm_with(3'd2, 5'b00100, 32'h0);
        repeat (3) begin
            stage_tvalid = 5'b00100; stage_tready = 5'b00000;
            stage_payload[2*PW +: PW] = 32'h0;
            tick();
        end
        check("stall_count", entry_count, 3);
        check("stall_state", state, 1);
        while (m_phase != 3) begin
            force_trigger();
            tick();
        end
        idle_stages();
        drain(0, -1);
        if (got_q.size() > 0) begin
            check("stall_map", got_q[0][EW-1 -: NS], 5'b00100);
            check("stall_fire", got_q[0][FIRE_LO +: NS], 0);
        end
`endif

        // Randomized capture rounds with random config, stray arms and random drain pacing.
        for (int r = 0; r < 6; r++) begin
            int cyc;
            random_stages();
            arm_with(3'($urandom_range(0, NS - 1)), NS'($urandom_range(1, 31)),
                     PW'($urandom_range(0, 15)));
            cyc = 0;
            while ((m_phase != 3) && (cyc < 700)) begin
                random_stages();
                if (cyc >= 400) force_trigger();
                arm = ($urandom_range(0, 15) == 0);
                capture_stage = 3'($urandom_range(0, NS - 1));
                tick();
                cyc++;
            end
            arm = 1'b0;
            idle_stages();
            check("rand_reach_drain", state, 3);
            if (m_phase == 3) begin
                drain($urandom_range(0, 2), -1);
            end else begin
                rst = 1'b1; tick(); rst = 1'b0;
            end
        end

        // Reset in the middle of a drain discards the remainder.
        arm_with(3'd0, 5'b00001, 32'h120);
        k = 0;
        while ((m_phase != 3) && (k < 20)) begin
            stage_tvalid = 5'b00001; stage_tready = 5'b00001;
            stage_payload[0 +: PW] = 32'h120 + 32'(4 * k);
            tick();
            k++;
        end
        idle_stages();
        drain(1, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_state", state, 0);
        check("mid_rst_valid", rd_tvalid, 0);
        check("mid_rst_count", entry_count, 0);

        // Capture still works after that reset.
        arm_with(3'd1, 5'b00010, 32'h55);
        k = 0;
        while ((m_phase != 3) && (k < 20)) begin
            stage_tvalid = 5'b00011; stage_tready = 5'b00011;
            stage_payload[0 +: PW]  = 32'h1000 + 32'(k);
            stage_payload[PW +: PW] = (k == 5) ? 32'h55 : 32'h2000 + 32'(k);
            tick();
            k++;
        end
        idle_stages();
        drain(0, -1);
        check("post_rst_beats", got_q.size(), 9);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
